barrel_shift_engine: RTL and testbench
======================================

# barrel_shift_engine

Parametrised multi-cycle barrel shift/rotate register, the successor to the fixed 16-bit, 8-bit-load rotator in the lab datapath. Adds full-width load, rotate, logical and arithmetic modes, a bounded per-cycle shift step, a start/busy/done handshake and carry/zero flags. Sits between the operand register file and the ALU result mux as a shared shifter resource.

## Interface
- WIDTH, 16: data width, at least 4.
- STEP_MAX, 4: maximum bit positions moved per clock, 1..WIDTH-1.
- AMT_W, $clog2(WIDTH): shift-amount width (derived, not overridden).

- i_clk  in  1  clock, rising edge.
- i_res  in  1  synchronous, active-high reset.
- i_load  in  1  load i_data into o_out.
- i_data  in  WIDTH  load value.
- i_start  in  1  start a shift using i_direction_right, i_mode, i_shift_amount.
- i_direction_right  in  1  1 = right, 0 = left.
- i_mode  in  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (treated as rotate).
- i_shift_amount  in  AMT_W  total shift, 0..WIDTH-1.
- o_out  out  WIDTH  shift register contents.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_carry  out  1  last bit shifted past the edge.
- o_zero  out  1  o_out == 0, combinational from register.

## Operation
- States: IDLE, SHIFT.
- Priority per edge: i_res > i_load > i_start.
- i_res: o_out=0, o_carry=0, o_busy=0, o_done=0, state IDLE, remaining count 0.
- i_load (any state): o_out=i_data (full width), o_carry=0, state IDLE, no o_done. Aborts an in-flight shift.
- i_start in IDLE without load: latch direction, mode and amount.
  - Amount 0: stay IDLE, o_done=1 next cycle, o_out and o_carry unchanged.
  - Otherwise: go to SHIFT with remaining=amount.
- i_start while in SHIFT: ignored; latched operands do not change.
- SHIFT, each cycle: step = min(remaining, STEP_MAX), apply step, remaining -= step. When remaining reaches 0, return to IDLE and pulse o_done.
- Modes:
  - Rotate: bits wrap.
  - Logical: zero fill.
  - Arithmetic right: fill with o_out[WIDTH-1].
  - Arithmetic left: identical to logical left.
- o_carry updates on each step with the last bit shifted out. The final value equals old[k-1] for a right shift by k and old[WIDTH-k] for a left shift by k, where old is the value at start.
- i_shift_amount values at or above WIDTH are impossible by width when WIDTH is a power of two. Otherwise they saturate to WIDTH-1.

## Timing
- Start accepted at edge t.
- o_busy=1 for cycles t+1 .. t+N, where N = ceil(amount/STEP_MAX).
- o_out takes intermediate values at edges t+1 .. t+N.
- At edge t+N (final step): o_out holds the final value, o_busy falls and o_done rises for exactly one cycle. Back-to-back start is legal in that cycle.
- Amount 0: o_done high at t+1, o_busy never asserted.
- Load latency is 1 cycle. o_zero follows o_out with no added latency.

## Structure
- Package barrel_shift_pkg holds:
  - mode typedef/localparams MODE_ROT, MODE_LSL, MODE_ASR, MODE_RSVD;
  - state encoding ST_IDLE, ST_SHIFT.
- Sub-module barrel_shift_step: combinational, shifts by 0..STEP_MAX given direction and mode, returns the result and the carry bit. It is instantiated once, and the engine holds the FSM, counter and registers.

## Test plan
WIDTH=16, STEP_MAX=4 for all scenarios.
- Rotate right 4: load 16'h00A5, start -> 1 busy cycle, o_out=16'h500A, o_carry=0, single o_done pulse.
- Logical left 9: load 16'h8001, start -> o_out goes 16'h0010, 16'h0100, 16'h0200 over 3 cycles; o_carry=0; o_done with the final value.
- Arithmetic right 15:
  - 16'h8000 -> 16'hFFFF after 4 cycles.
  - 16'h4000 -> 16'h0000 with o_zero=1.
- Rotate left 15: 16'h0001 -> 16'h8000 in 4 cycles. Amount 0 -> o_done at t+1, o_busy stays low, o_out unchanged.
- Load during shift: load 16'h1234 in the 2nd SHIFT cycle of a 4-cycle op -> o_out=16'h1234, o_busy=0, no o_done. i_start during SHIFT is ignored. Load and start in the same cycle -> load only.
- Reset mid-SHIFT: assert i_res -> next edge o_out=0, o_carry=0, o_busy=0, o_done=0. A new start after release behaves normally.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: shift mode codes and FSM state encoding shared by the barrel shift engine
package barrel_shift_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_ROT  = 2'd0;
    localparam mode_t MODE_LSL  = 2'd1;
    localparam mode_t MODE_ASR  = 2'd2;
    localparam mode_t MODE_RSVD = 2'd3;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/barrel_shift_step.sv
// barrel_shift_step: combinational shift of data by 0..STEP_MAX (right/left, mode) giving result and last bit shifted out
module barrel_shift_step
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP_MAX = 4,
    parameter int AMT_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] step,
    input  logic             right,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] res,
    output logic             carry
);
    always_comb begin
        res   = data;
        carry = 1'b0;
        for (int i = 0; i < STEP_MAX; i++) begin
            if (AMT_W'(i) < step) begin
                carry = right ? res[0] : res[WIDTH-1];
                res   = right ? {mode == MODE_ASR ? res[WIDTH-1] : (mode == MODE_LSL ? 1'b0 : res[0]), res[WIDTH-1:1]}
                              : {res[WIDTH-2:0], (mode == MODE_ROT || mode == MODE_RSVD) ? res[WIDTH-1] : 1'b0};
            end
        end
    end
endmodule

// File: rtl/barrel_shift_engine.sv
// barrel_shift_engine: multi-cycle shift/rotate register; i_load/i_data load, i_start/i_direction_right/i_mode/i_shift_amount start, o_out/o_busy/o_done/o_carry/o_zero status
module barrel_shift_engine
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP_MAX = 4,
    localparam int AMT_W   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_start,
    input  logic             i_direction_right,
    input  logic [1:0]       i_mode,
    input  logic [AMT_W-1:0] i_shift_amount,
    output logic [WIDTH-1:0] o_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_carry,
    output logic             o_zero
);
    state_t state, state_nxt;
    logic [AMT_W-1:0] rem, amt, step;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] step_res;
    logic             step_carry, last;

    if ((1 << AMT_W) == WIDTH) begin : g_pow2
        assign amt = i_shift_amount;
    end else begin : g_sat
        assign amt = (i_shift_amount > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : i_shift_amount;
    end

    assign step   = (rem > AMT_W'(STEP_MAX)) ? AMT_W'(STEP_MAX) : rem;
    assign last   = (rem == step);
    assign o_busy = (state == ST_SHIFT);
    assign o_zero = ~|o_out;

    barrel_shift_step #(.WIDTH(WIDTH), .STEP_MAX(STEP_MAX), .AMT_W(AMT_W)) u_step (
        .data  (o_out),
        .step  (step),
        .right (dir),
        .mode  (mode),
        .res   (step_res),
        .carry (step_carry)
    );

    always_comb begin
        state_nxt = state;
        if (i_load)
            state_nxt = ST_IDLE;
        else if (state == ST_IDLE)
            state_nxt = (i_start && amt != '0) ? ST_SHIFT : ST_IDLE;
        else
            state_nxt = last ? ST_IDLE : ST_SHIFT;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state   <= ST_IDLE;
            o_out   <= '0;
            o_carry <= 1'b0;
            o_done  <= 1'b0;
            rem     <= '0;
            dir     <= 1'b0;
            mode    <= MODE_ROT;
        end else begin
            state  <= state_nxt;
            o_done <= 1'b0;
            if (i_load) begin
                o_out   <= i_data;
                o_carry <= 1'b0;
                rem     <= '0;
            end else if (state == ST_IDLE) begin
                if (i_start) begin
                    dir    <= i_direction_right;
                    mode   <= i_mode;
                    rem    <= amt;
                    o_done <= (amt == '0);
                end
            end else begin
                o_out   <= step_res;
                o_carry <= step_carry;
                rem     <= rem - step;
                o_done  <= last;
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_engine.sv
// tb_barrel_shift_engine: directed plan scenarios plus randomized traffic checked against a cycle-level arithmetic model
module tb_barrel_shift_engine;
    localparam int W  = 16;
    localparam int SM = 4;

    logic          i_clk = 1'b0;
    logic          i_res, i_load, i_start, i_direction_right;
    logic [W-1:0]  i_data;
    logic [1:0]    i_mode;
    logic [3:0]    i_shift_amount;
    logic [W-1:0]  o_out;
    logic          o_busy, o_done, o_carry, o_zero;

    int            n_cmp = 0;
    int            n_err = 0;

    logic [W-1:0]  m_out;
    logic          m_carry, m_busy, m_done, m_dir;
    logic [1:0]    m_mode;
    int            m_rem, m_k;

    always #5 i_clk = ~i_clk;

    barrel_shift_engine #(.WIDTH(W), .STEP_MAX(SM)) dut (
        .i_clk             (i_clk),
        .i_res             (i_res),
        .i_load            (i_load),
        .i_data            (i_data),
        .i_start           (i_start),
        .i_direction_right (i_direction_right),
        .i_mode            (i_mode),
        .i_shift_amount    (i_shift_amount),
        .o_out             (o_out),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_carry           (o_carry),
        .o_zero            (o_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] shf(input logic [W-1:0] v, input logic r, input logic [1:0] md, input int k);
        logic signed [W-1:0] sv;
        sv = v;
        if (r) begin
            if (md == 2'd2) return sv >>> k;
            if (md == 2'd1) return v >> k;
            return (v >> k) | (v << (W - k));
        end
        if (md == 2'd1 || md == 2'd2) return v << k;
        return (v << k) | (v >> (W - k));
    endfunction

    task automatic tick(input logic ld, input logic [W-1:0] d, input logic st, input logic dr,
                        input logic [1:0] md, input logic [3:0] am, input logic rs);
        i_load = ld; i_data = d; i_start = st; i_direction_right = dr;
        i_mode = md; i_shift_amount = am; i_res = rs;
        @(posedge i_clk);
        if (rs) begin
            m_out = '0; m_carry = 0; m_busy = 0; m_done = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (ld) begin
                m_out = d; m_carry = 0; m_busy = 0; m_rem = 0;
            end else if (!m_busy) begin
                if (st) begin
                    m_dir = dr; m_mode = md; m_rem = int'(am);
                    m_busy = (am != 0);
                    m_done = (am == 0);
                end
            end else begin
                m_k = (m_rem < SM) ? m_rem : SM;
                m_carry = m_dir ? m_out[m_k-1] : m_out[W-m_k];
                m_out = shf(m_out, m_dir, m_mode, m_k);
                m_rem -= m_k;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        #1;
        check("out", o_out, m_out);
        check("busy", o_busy, m_busy);
        check("done", o_done, m_done);
        check("carry", o_carry, m_carry);
        check("zero", o_zero, m_out == '0);
    endtask

    task automatic idle();
        tick(0, '0, 0, 0, 2'd0, 4'd0, 0);
    endtask

    task automatic load(input logic [W-1:0] d);
        tick(1, d, 0, 0, 2'd0, 4'd0, 0);
    endtask

    task automatic start(input logic dr, input logic [1:0] md, input logic [3:0] am);
        tick(0, '0, 1, dr, md, am, 0);
    endtask

    initial begin
        m_dir = 0; m_mode = 0;
        tick(0, '0, 0, 0, 2'd0, 4'd0, 1);
        check("rst_out", o_out, 16'h0000);
        check("rst_busy", o_busy, 1'b0);

        load(16'h00A5); start(1, 2'd0, 4'd4);
        check("rr4_busy", o_busy, 1'b1);
        idle();
        check("rr4_out", o_out, 16'h500A);
        check("rr4_carry", o_carry, 1'b0);
        check("rr4_done", o_done, 1'b1);
        idle();
        check("rr4_pulse", o_done, 1'b0);

        load(16'h8001); start(0, 2'd1, 4'd9);
        idle(); check("lsl9_s1", o_out, 16'h0010);
        idle(); check("lsl9_s2", o_out, 16'h0100);
        idle(); check("lsl9_s3", o_out, 16'h0200);
        check("lsl9_done", o_done, 1'b1);
        check("lsl9_carry", o_carry, 1'b0);

        load(16'h8000); start(1, 2'd2, 4'd15);
        repeat (4) idle();
        check("asr15_neg", o_out, 16'hFFFF);
        check("asr15_done", o_done, 1'b1);
        load(16'h4000); start(1, 2'd2, 4'd15);
        repeat (4) idle();
        check("asr15_pos", o_out, 16'h0000);
        check("asr15_zero", o_zero, 1'b1);

        load(16'h0001); start(0, 2'd0, 4'd15);
        repeat (4) idle();
        check("rol15_out", o_out, 16'h8000);
        start(0, 2'd0, 4'd0);
        check("amt0_done", o_done, 1'b1);
        check("amt0_busy", o_busy, 1'b0);
        check("amt0_out", o_out, 16'h8000);

        load(16'hFFF0); start(1, 2'd0, 4'd13);
        idle();
        load(16'h1234);
        check("abort_out", o_out, 16'h1234);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        idle();
        check("abort_nodone", o_done, 1'b0);

        load(16'h00F0); start(1, 2'd0, 4'd8);
        start(0, 2'd1, 4'd1);
        idle();
        check("ign_out", o_out, 16'hF000);
        check("ign_done", o_done, 1'b1);

        tick(1, 16'h0F0F, 1, 1, 2'd0, 4'd4, 0);
        check("ldst_busy", o_busy, 1'b0);
        check("ldst_out", o_out, 16'h0F0F);

        start(1, 2'd0, 4'd12); idle();
        tick(0, '0, 0, 0, 2'd0, 4'd0, 1);
        check("rmid_out", o_out, 16'h0000);
        check("rmid_busy", o_busy, 1'b0);
        check("rmid_done", o_done, 1'b0);
        check("rmid_carry", o_carry, 1'b0);
        load(16'h00A5); start(1, 2'd0, 4'd4); idle();
        check("rmid_restart", o_out, 16'h500A);

        for (int n = 0; n < 1500; n++)
            tick($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
                 2'($urandom), 4'($urandom), $urandom_range(0, 59) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
